regfile_sb: RTL and testbench

- Parametrised general-purpose register file with a write-reservation scoreboard, successor to the fixed 8x16 register file in the core.
- Width and register count are generalised; register 0 reads as zero.
- Adds asynchronous reset, an optional write-to-read bypass, a debug read port and per-register pending bits for multi-cycle units.
- Sits between decode (rs1/rs2/rsv), writeback (we/rd/rd_din) and the debug interface.

---
 rtl/regfile_sb.sv | 142 ++++++++++++++
 tb/tb_regfile_sb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//
// Parametrised general-purpose register file with a per-register
// write-reservation scoreboard. Decode reads two operands (rs1/rs2) and
// reserves destinations of multi-cycle operations (rsv_*). Writeback
// (we/rd/rd_din) stores results and releases reservations. The debug port
// (dbg_sel/dbg_dout) reads stored state without any forwarding.
// Register 0 is hardwired to zero. Indices >= NREG behave like register 0.
//
// Parameters:
//   BITS   - data width of each register
//   RBITS  - register index width
//   NREG   - number of registers, index 0 included (NREG <= 2**RBITS)
//   BYPASS - 1: same-cycle writeback data is forwarded to the read ports
//            0: read ports see stored values only
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   run        - global enable for writes and reservations
//   we/rd/rd_din            - writeback enable, index and data
//   rs1/rs2                 - read port indices
//   rs1_dout/rs2_dout       - read port data (combinational)
//   rs1_busy/rs2_busy       - read register has an outstanding reservation
//   rsv_valid/rsv_rd        - reservation request and target register
//   rsv_ready               - reservation is accepted this cycle
//   dbg_sel/dbg_dout        - debug read index and data (combinational)
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int BITS   = 16,
    parameter int RBITS  = 3,
    parameter int NREG   = 8,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             we,
    input  logic [RBITS-1:0] rd,
    input  logic [BITS-1:0]  rd_din,
    input  logic [RBITS-1:0] rs1,
    input  logic [RBITS-1:0] rs2,
    output logic [BITS-1:0]  rs1_dout,
    output logic [BITS-1:0]  rs2_dout,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             rsv_valid,
    input  logic [RBITS-1:0] rsv_rd,
    output logic             rsv_ready,
    input  logic [RBITS-1:0] dbg_sel,
    output logic [BITS-1:0]  dbg_dout
);

    // Storage spans the whole index space so any index addresses it
    // directly; entries 0 and >= NREG are never written and stay zero.
    localparam int             DEPTH  = 1 << RBITS;
    localparam logic [RBITS:0] NREG_W = (RBITS + 1)'(NREG);
    localparam logic           BYP_EN = (BYPASS != 0);

    logic [BITS-1:0]  regs_q [DEPTH];
    logic [BITS-1:0]  regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    logic wr_en;
    logic rsv_take;
    logic rs1_hit;
    logic rs2_hit;

    // True for indices that name real storage (1..NREG-1).
    function automatic logic in_range(input logic [RBITS-1:0] idx);
        return (idx != '0) && ({1'b0, idx} < NREG_W);
    endfunction

    // rst_n is folded into the write enable so that bypassed data cannot
    // leak onto the read ports while reset holds everything at zero.
    assign wr_en = run & rst_n & we & in_range(rd);

    // Readiness looks only at registered pend bits; a write landing in the
    // same cycle does not make a stalled reservation ready early.
    assign rsv_ready = run & rst_n & (~in_range(rsv_rd) | ~pend_q[rsv_rd]);
    assign rsv_take  = rsv_valid & rsv_ready & in_range(rsv_rd);

    // Next-state: the reservation is applied after the write so that a
    // same-cycle write and reservation of one register leaves it pending
    // while still storing the written data.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_en) begin
            regs_d[rd] = rd_din;
            pend_d[rd] = 1'b0;
        end
        if (rsv_take) begin
            pend_d[rsv_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    // A bypass hit forwards the writeback data and also hides the pending
    // bit, since the reservation is being satisfied right now.
    assign rs1_hit = BYP_EN & wr_en & (rd == rs1);
    assign rs2_hit = BYP_EN & wr_en & (rd == rs2);

    always_comb begin
        rs1_dout = '0;
        rs1_busy = 1'b0;
        if (in_range(rs1)) begin
            rs1_dout = rs1_hit ? rd_din : regs_q[rs1];
            rs1_busy = pend_q[rs1] & ~rs1_hit;
        end
    end

    always_comb begin
        rs2_dout = '0;
        rs2_busy = 1'b0;
        if (in_range(rs2)) begin
            rs2_dout = rs2_hit ? rd_din : regs_q[rs2];
            rs2_busy = pend_q[rs2] & ~rs2_hit;
        end
    end

    always_comb begin
        dbg_dout = '0;
        if (in_range(dbg_sel)) begin
            dbg_dout = regs_q[dbg_sel];
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Two register files share one stimulus stream: instance A uses the default
// 8x16 configuration with forwarding, instance B is 6x32 without forwarding,
// so indices 6 and 7 are out of range for B only.
module tb_regfile_sb;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        we;
   logic [2:0]  rd;
   logic [31:0] rdDin;
   logic [2:0]  rs1;
   logic [2:0]  rs2;
   logic        rsvValid;
   logic [2:0]  rsvRd;
   logic [2:0]  dbgSel;

   logic [15:0] aRs1Dout, aRs2Dout, aDbgDout;
   logic        aRs1Busy, aRs2Busy, aRsvReady;
   logic [31:0] bRs1Dout, bRs2Dout, bDbgDout;
   logic        bRs1Busy, bRs2Busy, bRsvReady;

   int nVectors;
   int nMiscompares;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sbEntry_t;

   sbEntry_t sbQ[$];

   // Reference state for both configurations (index 0 = A, 1 = B).
   logic [31:0] mReg  [2][8];
   logic        mPend [2][8];

   regfile_sb #(.BITS(16), .RBITS(3), .NREG(8), .BYPASS(1)) u_a (
      .clk(clk), .rst_n(rst_n), .run(run), .we(we), .rd(rd),
      .rd_din(rdDin[15:0]), .rs1(rs1), .rs2(rs2),
      .rs1_dout(aRs1Dout), .rs2_dout(aRs2Dout),
      .rs1_busy(aRs1Busy), .rs2_busy(aRs2Busy),
      .rsv_valid(rsvValid), .rsv_rd(rsvRd), .rsv_ready(aRsvReady),
      .dbg_sel(dbgSel), .dbg_dout(aDbgDout)
   );

   regfile_sb #(.BITS(32), .RBITS(3), .NREG(6), .BYPASS(0)) u_b (
      .clk(clk), .rst_n(rst_n), .run(run), .we(we), .rd(rd),
      .rd_din(rdDin), .rs1(rs1), .rs2(rs2),
      .rs1_dout(bRs1Dout), .rs2_dout(bRs2Dout),
      .rs1_busy(bRs1Busy), .rs2_busy(bRs2Busy),
      .rsv_valid(rsvValid), .rsv_rd(rsvRd), .rsv_ready(bRsvReady),
      .dbg_sel(dbgSel), .dbg_dout(bDbgDout)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int nregOf(input int c);
      return (c == 0) ? 8 : 6;
   endfunction

   function automatic logic [31:0] maskOf(input int c);
      return (c == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   endfunction

   function automatic logic bypassOf(input int c);
      return c == 0;
   endfunction

   function automatic logic inRange(input int c, input logic [2:0] idx);
      return (idx != 3'd0) && (int'(idx) < nregOf(c));
   endfunction

   function automatic logic modelWrite(input int c);
      return rst_n && run && we && inRange(c, rd);
   endfunction

   function automatic logic [31:0] modelRead(input int c, input logic [2:0] idx);
      if (!inRange(c, idx)) return 32'h0;
      if (bypassOf(c) && modelWrite(c) && rd == idx) return rdDin & maskOf(c);
      return mReg[c][idx];
   endfunction

   function automatic logic modelBusy(input int c, input logic [2:0] idx);
      if (!inRange(c, idx)) return 1'b0;
      if (bypassOf(c) && modelWrite(c) && rd == idx) return 1'b0;
      return mPend[c][idx];
   endfunction

   function automatic logic modelReady(input int c);
      return rst_n && run && (!inRange(c, rsvRd) || !mPend[c][rsvRd]);
   endfunction

   function automatic logic [31:0] modelDbg(input int c);
      return inRange(c, dbgSel) ? mReg[c][dbgSel] : 32'h0;
   endfunction

   // Single comparison point: counts every vector and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVectors++;
      if (obs !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clearModel();
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 8; i++) begin
            mReg[c][i]  = 32'h0;
            mPend[c][i] = 1'b0;
         end
      end
   endtask

   // Queue the expected outputs of both instances for the current inputs.
   task automatic pushExpected();
      string p;
      for (int c = 0; c < 2; c++) begin
         p = (c == 0) ? "A" : "B";
         sbQ.push_back('{{p, ".rs1_dout"},  modelRead(c, rs1)});
         sbQ.push_back('{{p, ".rs2_dout"},  modelRead(c, rs2)});
         sbQ.push_back('{{p, ".rs1_busy"},  32'(modelBusy(c, rs1))});
         sbQ.push_back('{{p, ".rs2_busy"},  32'(modelBusy(c, rs2))});
         sbQ.push_back('{{p, ".rsv_ready"}, 32'(modelReady(c))});
         sbQ.push_back('{{p, ".dbg_dout"},  modelDbg(c)});
      end
   endtask

   // Pop queued expectations against what the instances currently show.
   task automatic checkScoreboard();
      logic [31:0] act [12];
      sbEntry_t    e;
      act[0]  = 32'(aRs1Dout);  act[1]  = 32'(aRs2Dout);
      act[2]  = 32'(aRs1Busy);  act[3]  = 32'(aRs2Busy);
      act[4]  = 32'(aRsvReady); act[5]  = 32'(aDbgDout);
      act[6]  = bRs1Dout;       act[7]  = bRs2Dout;
      act[8]  = 32'(bRs1Busy);  act[9]  = 32'(bRs2Busy);
      act[10] = 32'(bRsvReady); act[11] = bDbgDout;
      for (int i = 0; i < 12; i++) begin
         e = sbQ.pop_front();
         checkOutput(e.tag, act[i], e.exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and check the
   // combinational response before the next rising edge.
   task automatic applyStimulus(input logic iRun, input logic iWe, input logic [2:0] iRd,
                                input logic [31:0] iDin, input logic [2:0] iRs1,
                                input logic [2:0] iRs2, input logic iRsvValid,
                                input logic [2:0] iRsvRd, input logic [2:0] iDbg);
      @(negedge clk);
      run = iRun; we = iWe; rd = iRd; rdDin = iDin;
      rs1 = iRs1; rs2 = iRs2; rsvValid = iRsvValid; rsvRd = iRsvRd; dbgSel = iDbg;
      #1;
      pushExpected();
      #1;
      checkScoreboard();
   endtask

   // Advance the model across one rising edge.
   task automatic clockEdge();
      logic [31:0] nReg  [2][8];
      logic        nPend [2][8];
      nReg  = mReg;
      nPend = mPend;
      for (int c = 0; c < 2; c++) begin
         if (modelWrite(c)) begin
            nReg[c][rd]  = rdDin & maskOf(c);
            nPend[c][rd] = 1'b0;
         end
         if (rsvValid && modelReady(c) && inRange(c, rsvRd)) nPend[c][rsvRd] = 1'b1;
      end
      @(posedge clk);
      if (rst_n) begin
         mReg  = nReg;
         mPend = nPend;
      end else begin
         clearModel();
      end
   endtask

   // Assert reset between edges and check outputs drop with no clock.
   task automatic resetMidCycle();
      #2;
      rst_n = 1'b0;
      clearModel();
      #1;
      pushExpected();
      checkScoreboard();
      checkOutput("A.rs1_dout.in_reset",  32'(aRs1Dout),  32'h0);
      checkOutput("A.rs1_busy.in_reset",  32'(aRs1Busy),  32'h0);
      checkOutput("A.rsv_ready.in_reset", 32'(aRsvReady), 32'h0);
      clockEdge();
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      nVectors = 0;
      nMiscompares = 0;
      rst_n = 1'b0;
      run = 1'b0; we = 1'b0; rd = 3'd0; rdDin = 32'h0;
      rs1 = 3'd0; rs2 = 3'd0; rsvValid = 1'b0; rsvRd = 3'd0; dbgSel = 3'd0;
      clearModel();

      // Under reset with everything requested: all outputs must be zero.
      applyStimulus(1, 1, 3, 32'hDEAD_BEEF, 3, 3, 1, 2, 3);
      checkOutput("A.rs1_dout.reset", 32'(aRs1Dout), 32'h0);
      checkOutput("A.rsv_ready.reset", 32'(aRsvReady), 32'h0);
      clockEdge();
      #2 rst_n = 1'b1;

      // Write r3 then read it back through both ports and debug.
      applyStimulus(1, 1, 3, 32'hDEAD_BEEF, 3, 0, 0, 0, 3);
      checkOutput("A.rs1_dout.bypass_r3", 32'(aRs1Dout), 32'h0000_BEEF);
      checkOutput("B.rs1_dout.nobypass_r3", bRs1Dout, 32'h0);
      clockEdge();
      applyStimulus(1, 0, 0, 32'h0, 3, 0, 0, 0, 3);
      checkOutput("A.rs1_dout.r3", 32'(aRs1Dout), 32'h0000_BEEF);
      checkOutput("A.dbg_dout.r3", 32'(aDbgDout), 32'h0000_BEEF);
      checkOutput("A.rs2_dout.r0", 32'(aRs2Dout), 32'h0);
      checkOutput("B.rs1_dout.r3", bRs1Dout, 32'hDEAD_BEEF);
      clockEdge();

      // Writes to r0 and writes with run low are dropped.
      applyStimulus(1, 1, 0, 32'h0000_1234, 0, 2, 0, 0, 0);
      clockEdge();
      applyStimulus(0, 1, 2, 32'h0000_5555, 0, 2, 0, 0, 2);
      clockEdge();
      applyStimulus(1, 0, 0, 32'h0, 0, 2, 0, 0, 2);
      checkOutput("A.rs1_dout.r0_write", 32'(aRs1Dout), 32'h0);
      checkOutput("A.rs2_dout.r2_norun", 32'(aRs2Dout), 32'h0);
      clockEdge();

      // Same-cycle write and read of r5: forwarded on A, debug not.
      applyStimulus(1, 1, 5, 32'h0000_00A5, 5, 5, 0, 0, 5);
      checkOutput("A.rs1_dout.bypass_r5", 32'(aRs1Dout), 32'h0000_00A5);
      checkOutput("A.rs2_dout.bypass_r5", 32'(aRs2Dout), 32'h0000_00A5);
      checkOutput("A.dbg_dout.r5_same", 32'(aDbgDout), 32'h0);
      clockEdge();
      applyStimulus(1, 0, 0, 32'h0, 0, 0, 0, 0, 5);
      checkOutput("A.dbg_dout.r5_next", 32'(aDbgDout), 32'h0000_00A5);
      clockEdge();

      // Reserve r4, stall a second reservation until the write lands.
      applyStimulus(1, 0, 0, 32'h0, 4, 0, 1, 4, 0);
      checkOutput("A.rsv_ready.r4_first", 32'(aRsvReady), 32'h1);
      clockEdge();
      applyStimulus(1, 0, 0, 32'h0, 4, 0, 1, 4, 0);
      checkOutput("A.rsv_ready.r4_stall", 32'(aRsvReady), 32'h0);
      checkOutput("A.rs1_busy.r4", 32'(aRs1Busy), 32'h1);
      clockEdge();
      applyStimulus(1, 0, 0, 32'h0, 4, 0, 1, 4, 0);
      clockEdge();
      applyStimulus(1, 1, 4, 32'h0000_4444, 4, 4, 1, 4, 4);
      checkOutput("A.rs1_busy.r4_wrcycle", 32'(aRs1Busy), 32'h0);
      checkOutput("B.rs1_busy.r4_wrcycle", 32'(bRs1Busy), 32'h1);
      checkOutput("A.rsv_ready.r4_wrcycle", 32'(aRsvReady), 32'h0);
      clockEdge();
      applyStimulus(1, 0, 0, 32'h0, 4, 4, 1, 4, 4);
      checkOutput("B.rs1_busy.r4_after", 32'(bRs1Busy), 32'h0);
      checkOutput("A.rsv_ready.r4_again", 32'(aRsvReady), 32'h1);
      clockEdge();
      applyStimulus(1, 0, 0, 32'h0, 4, 0, 0, 0, 4);
      checkOutput("A.rs1_busy.r4_rereserved", 32'(aRs1Busy), 32'h1);
      clockEdge();

      // Simultaneous write and reservation of r6 (out of range on B).
      applyStimulus(1, 1, 6, 32'h0000_6666, 0, 0, 1, 6, 0);
      clockEdge();
      applyStimulus(1, 0, 0, 32'h0, 6, 0, 0, 0, 6);
      checkOutput("A.rs1_busy.r6", 32'(aRs1Busy), 32'h1);
      checkOutput("A.dbg_dout.r6", 32'(aDbgDout), 32'h0000_6666);
      checkOutput("B.dbg_dout.r6_oor", bDbgDout, 32'h0);
      clockEdge();

      // Index 7 on B: write discarded, reads zero, reservation no-op.
      applyStimulus(1, 1, 7, 32'h7777_7777, 7, 7, 1, 7, 7);
      clockEdge();
      applyStimulus(1, 0, 0, 32'h0, 7, 0, 1, 7, 7);
      checkOutput("B.rs1_dout.r7", bRs1Dout, 32'h0);
      checkOutput("B.rs1_busy.r7", 32'(bRs1Busy), 32'h0);
      checkOutput("B.rsv_ready.r7", 32'(bRsvReady), 32'h1);
      clockEdge();

      // Reset asserted mid-cycle with a write and reservation in flight.
      applyStimulus(1, 1, 6, 32'h0000_7777, 6, 3, 1, 6, 6);
      clockEdge();
      resetMidCycle();

      // Random traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         applyStimulus($urandom_range(0, 7) != 0, 1'($urandom), 3'($urandom),
                       $urandom, 3'($urandom), 3'($urandom), 1'($urandom),
                       3'($urandom), 3'($urandom));
         clockEdge();
         if ($urandom_range(0, 49) == 0) resetMidCycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
